// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the route dispatch front end.
//   FIELD_W         - default width of each route field
//   DIR_P0..DIR_P2  - the three legal (one-hot) direction codes
//   state_e         - dispatch FSM states
//   is_onehot3()    - true when a 3-bit direction selects exactly one channel
package router_pkg;

  localparam int FIELD_W = 30;

  localparam logic [2:0] DIR_P0 = 3'b001;
  localparam logic [2:0] DIR_P1 = 3'b010;
  localparam logic [2:0] DIR_P2 = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    SEND   = 2'd2,
    DROP   = 2'd3
  } state_e;

  function automatic logic is_onehot3(input logic [2:0] dir);
    return (dir == DIR_P0) || (dir == DIR_P1) || (dir == DIR_P2);
  endfunction

endpackage

// File: rtl/router_dispatch_fifo.sv
// router_dispatch_fifo: synchronous FIFO holding whole packets.
//   clk, rst            - clock, synchronous active-high reset (empties FIFO)
//   push, push_data     - write request and entry; ignored when full unless
//                         a pop happens in the same cycle
//   pop, pop_data       - read request; pop_data always shows the head entry
//   full, empty         - occupancy flags from a (log2 DEPTH)+1-bit count
module router_dispatch_fifo #(
  parameter int WIDTH = 92,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_ok   = pop && !empty;
  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still safe when both happen together.
  assign push_ok  = push && (!full || pop_ok);
  // Head is read combinationally so the route fields are visible at once.
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);  // power-of-two depth wraps naturally
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/router_dispatch.sv
// router_dispatch: buffers packets, presents the head's route fields to the
// external combinational decision logic, registers the returned direction and
// delivers the payload on the selected channel with valid/ready.
//   clk, rst                     - clock, synchronous active-high reset
//   in_valid/in_ready            - upstream handshake; in_ready = !full
//   in_dest/in_local/in_data     - packet route fields and payload
//   rt_a/rt_b                    - head route fields (0 when FIFO empty)
//   rt_dir                       - decision for rt_a/rt_b, sampled in LOOKUP
//   out_valid/out_ready          - per-channel handshake, at most one valid
//   out_data                     - payload shared by all channels
//   drop_cnt                     - saturating count of non-one-hot decisions
// DEPTH must be a power of two and at least 2.
module router_dispatch #(
  parameter int FIELD_W = router_pkg::FIELD_W,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FIELD_W-1:0] in_dest,
  input  logic [FIELD_W-1:0] in_local,
  input  logic [DATA_W-1:0]  in_data,
  output logic [FIELD_W-1:0] rt_a,
  output logic [FIELD_W-1:0] rt_b,
  input  logic [2:0]         rt_dir,
  output logic [2:0]         out_valid,
  input  logic [2:0]         out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [7:0]         drop_cnt
);

  import router_pkg::*;

  localparam int ENTRY_W = 2*FIELD_W + DATA_W;

  state_e              state_q, state_d;
  logic [2:0]          dir_q, dir_d;
  logic [DATA_W-1:0]   payload_q, payload_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  logic                fifo_full, fifo_empty;
  logic                push, pop;
  logic [ENTRY_W-1:0]  head;
  logic [FIELD_W-1:0]  head_dest, head_local;
  logic [DATA_W-1:0]   head_data;

  assign in_ready = !rst && !fifo_full;
  assign push     = in_valid && in_ready;

  router_dispatch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({in_dest, in_local, in_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_dest, head_local, head_data} = head;
  assign rt_a     = fifo_empty ? '0 : head_dest;
  assign rt_b     = fifo_empty ? '0 : head_local;
  assign out_data = payload_q;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    payload_d  = payload_q;
    drop_cnt_d = drop_cnt_q;
    out_valid  = 3'b000;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        // A push this cycle lands in the FIFO at the edge, so LOOKUP can
        // already see it; this gives the one-cycle push-to-LOOKUP latency.
        if (!fifo_empty || push) state_d = LOOKUP;
      end
      LOOKUP: begin
        pop       = 1'b1;
        dir_d     = rt_dir;
        payload_d = head_data;
        state_d   = is_onehot3(rt_dir) ? SEND : DROP;
      end
      SEND: begin
        out_valid = dir_q;
        // Only the selected channel's ready matters.
        if ((dir_q & out_ready) != 3'b000) state_d = IDLE;
      end
      DROP: begin
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dir_q      <= 3'b000;
      payload_q  <= '0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      payload_q  <= payload_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_router_dispatch.sv
// Directed bench for router_dispatch. The decision logic is modelled by
// returning the low 3 bits of the destination field as the direction.
module tb_router_dispatch;

  localparam int FW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_dest, in_local;
  logic [DW-1:0] in_data;
  logic [FW-1:0] rt_a, rt_b;
  logic [2:0]    rt_dir;
  logic [2:0]    out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  assign rt_dir = rt_a[2:0];

  router_dispatch #(.FIELD_W(FW), .DATA_W(DW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_local(in_local), .in_data(in_data),
    .rt_a(rt_a), .rt_b(rt_b), .rt_dir(rt_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_push  = 0;
  int          exp_drops = 0;
  logic [34:0] sb_q[$];
  logic        prev_hold = 1'b0;
  logic [2:0]  prev_valid = 3'b000;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sat_drops(input int d);
    return (d > 255) ? 64'd255 : 64'(d);
  endfunction

  task automatic set_pkt(input logic [2:0] dir, input logic [DW-1:0] data);
    in_valid = 1'b1;
    in_dest  = {1'b1, 26'($urandom), dir};
    in_local = 30'($urandom);
    in_data  = data;
  endtask

  // One clock: observe at the falling edge, return 1 time unit after rising.
  task automatic tick();
    logic [34:0] exp_e;
    @(negedge clk);
    if (in_valid && in_ready) begin
      n_push++;
      if ($countones(in_dest[2:0]) == 1) sb_q.push_back({in_dest[2:0], in_data});
      else exp_drops++;
    end
    if (prev_hold) begin
      chk("hold_valid", 64'(out_valid), 64'(prev_valid));
      chk("hold_data", 64'(out_data), 64'(prev_data));
    end
    if ((out_valid & out_ready) != 3'b000) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        exp_e = sb_q.pop_front();
        chk("out_dir", 64'(out_valid), 64'(exp_e[34:32]));
        chk("out_data", 64'(out_data), 64'(exp_e[31:0]));
        $display("[TB] delivered dir=%b data=%h", out_valid, out_data);
      end
    end
    prev_hold  = (out_valid != 3'b000) && ((out_valid & out_ready) == 3'b000);
    prev_valid = out_valid;
    prev_data  = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int quiet = 0;
    for (int i = 0; i < 400 && quiet < 4; i++) begin
      tick();
      if (out_valid == 3'b000 && rt_a == '0 && sb_q.size() == 0) quiet++;
      else quiet = 0;
    end
    chk("drain_sb_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int base;
    logic [FW-1:0] saved_local;

    rst = 1'b1; in_valid = 1'b0; out_ready = 3'b000;
    in_dest = '0; in_local = '0; in_data = '0;

    // Reset state
    repeat (3) tick();
    chk("in_ready_in_rst", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_rt_a", 64'(rt_a), 64'd0);
    chk("rst_rt_b", 64'(rt_b), 64'd0);

    // Single packet latency
    out_ready = 3'b111;
    set_pkt(3'b001, 32'hA5A5_0001);
    saved_local = in_local;
    tick();
    in_valid = 1'b0;
    chk("lookup_no_valid", 64'(out_valid), 64'd0);
    chk("lookup_rt_b", 64'(rt_b), 64'(saved_local));
    tick();
    chk("valid_at_t2", 64'(out_valid), 64'(3'b001));
    chk("data_at_t2", 64'(out_data), 64'(32'hA5A5_0001));
    tick();
    chk("valid_deassert", 64'(out_valid), 64'd0);

    // Ordered delivery with back-pressure on channel 1
    out_ready = 3'b101;
    set_pkt(3'b010, 32'h0000_0011); tick();
    set_pkt(3'b100, 32'h0000_0012); tick();
    set_pkt(3'b001, 32'h0000_0013); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && out_valid == 3'b000; i++) tick();
    chk("bp_valid", 64'(out_valid), 64'(3'b010));
    repeat (5) tick();
    chk("bp_still_valid", 64'(out_valid), 64'(3'b010));
    chk("bp_still_data", 64'(out_data), 64'(32'h0000_0011));
    out_ready = 3'b111;
    drain();

    // Fill the FIFO with all channels stalled
    out_ready = 3'b000;
    base = n_push;
    for (int i = 0; i < 20; i++) begin
      set_pkt(3'b001 << (i % 3), 32'hF000_0000 + 32'(i));
      tick();
      if (!in_ready) break;
    end
    in_valid = 1'b0;
    chk("accepted_before_stall", 64'(n_push - base), 64'd5);
    chk("in_ready_full", 64'(in_ready), 64'd0);

    // Push waiting on a full FIFO goes in once a slot frees, behind the rest
    set_pkt(3'b100, 32'hBEEF_0006);
    out_ready = 3'b111;
    base = n_push;
    for (int i = 0; i < 20 && n_push == base; i++) tick();
    in_valid = 1'b0;
    chk("swap_push_accepted", 64'(n_push - base), 64'd1);
    chk("full_again", 64'(in_ready), 64'd0);
    drain();

    // Drops: no valid decision, then saturation
    set_pkt(3'b000, 32'hDEAD_0000); tick();
    set_pkt(3'b011, 32'hDEAD_0001); tick();
    in_valid = 1'b0;
    drain();
    chk("drop_cnt_two", 64'(drop_cnt), sat_drops(exp_drops));
    base = n_push;
    for (int i = 0; i < 3000 && (n_push - base) < 300; i++) begin
      set_pkt((i % 2 == 0) ? 3'b000 : 3'b111, 32'(i));
      tick();
    end
    in_valid = 1'b0;
    drain();
    chk("forced_drops_pushed", 64'(n_push - base), 64'd300);
    chk("drop_cnt_sat", 64'(drop_cnt), sat_drops(exp_drops));
    chk("drop_cnt_255", 64'(drop_cnt), 64'd255);

    // Reset during SEND with packets queued
    out_ready = 3'b000;
    set_pkt(3'b001, 32'h5EED_0001); tick();
    set_pkt(3'b010, 32'h5EED_0002); tick();
    set_pkt(3'b100, 32'h5EED_0003); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && out_valid == 3'b000; i++) tick();
    chk("send_before_rst", 64'(out_valid), 64'(3'b001));
    rst = 1'b1;
    #1;
    chk("in_ready_mid_rst", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    sb_q.delete();
    prev_hold = 1'b0;
    exp_drops = 0;
    #1;
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_rt_a", 64'(rt_a), 64'd0);
    chk("post_rst_data", 64'(out_data), 64'd0);
    chk("post_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    out_ready = 3'b111;
    repeat (15) tick();
    chk("no_stale_packet", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
